// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the raw PS/2 set-2 byte stream into key events. Prefix bytes
//   (E0 extended, F0 break, E1 pause) are absorbed by a small FSM. Each
//   complete key event is queued in a first-word fall-through FIFO as
//   {ext, break, code, ascii}. The decoder also tracks the shift keys and
//   the caps-lock toggle.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   byte_data/_valid    received byte and its one-cycle strobe (no backpressure)
//   ev_valid/ev_ready   FIFO head handshake; pop on ev_valid & ev_ready
//   ev_code/ext/break   head scancode with prefix information
//   ev_ascii            head ASCII value (0x00 when none)
//   shift_o, caps_o     live modifier state
//   overflow            sticky flag: an event was dropped on a full FIFO
//
// Configuration
//   PS2_DECODER_ASCII_EN  when defined, a set-2 to ASCII table fills ev_ascii
//                         for non-extended make events; otherwise ev_ascii is 0.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       shift_o,
    output logic       caps_o,
    output logic       overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic          lsh_q, lsh_d, rsh_q, rsh_d, caps_q, caps_d;
    logic          ovf_q;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    logic          push, pop, full, wr_en;
    logic          new_ext, new_brk;
    logic [7:0]    new_code, new_ascii;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    endfunction

    // Controller replies and idle filler bytes that never form an event.
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

`ifdef PS2_DECODER_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [7:0] code,
                                            input logic shift, input logic caps);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
            8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
            8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
            8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
            8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
            8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
            8'h35: a = "y";  8'h1A: a = "z";
            8'h16: a = shift ? "!" : "1";  8'h1E: a = shift ? "@" : "2";
            8'h26: a = shift ? "#" : "3";  8'h25: a = shift ? "$" : "4";
            8'h2E: a = shift ? "%" : "5";  8'h36: a = shift ? "^" : "6";
            8'h3D: a = shift ? "&" : "7";  8'h3E: a = shift ? "*" : "8";
            8'h46: a = shift ? "(" : "9";  8'h45: a = shift ? ")" : "0";
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        // Letters follow shift XOR caps; digits ignore caps.
        if (a >= 8'h61 && a <= 8'h7A && (shift ^ caps))
            a = a - 8'h20;
        return a;
    endfunction
`endif

    // Prefix decode and modifier next-state
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        push     = 1'b0;
        new_ext  = 1'b0;
        new_brk  = 1'b0;
        new_code = byte_data;
        if (byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_data == 8'hE0)      state_d = S_E0;
                    else if (byte_data == 8'hF0) state_d = S_F0;
                    else if (byte_data == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else if (!is_discard(byte_data)) push = 1'b1;
                end
                S_E0: begin
                    if (byte_data == 8'hF0) state_d = S_E0F0;
                    else begin
                        state_d = S_IDLE;
                        if (!is_prefix(byte_data) && !is_discard(byte_data)) begin
                            push    = 1'b1;
                            new_ext = 1'b1;
                        end
                    end
                end
                S_F0, S_E0F0: begin
                    state_d = S_IDLE;
                    if (!is_prefix(byte_data) && !is_discard(byte_data)) begin
                        push    = 1'b1;
                        new_brk = 1'b1;
                        new_ext = (state_q == S_E0F0);
                    end
                end
                S_PAUSE: begin
                    // The pause key sends E1 plus seven bytes and has no break.
                    if (skip_q == 3'd1) begin
                        state_d  = S_IDLE;
                        skip_d   = 3'd0;
                        push     = 1'b1;
                        new_ext  = 1'b1;
                        new_code = 8'h77;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef PS2_DECODER_ASCII_EN
        // Uses modifier state from before this event's own update.
        new_ascii = (push && !new_ext && !new_brk) ?
                    to_ascii(new_code, lsh_q | rsh_q, caps_q) : 8'h00;
`else
        new_ascii = 8'h00;
`endif

        lsh_d  = lsh_q;
        rsh_d  = rsh_q;
        caps_d = caps_q;
        if (push && !new_ext) begin
            if (new_code == 8'h12) lsh_d = !new_brk;
            if (new_code == 8'h59) rsh_d = !new_brk;
            if (new_code == 8'h58 && !new_brk) caps_d = !caps_q;
        end
    end

    assign full  = (cnt_q == FULL_CNT);
    assign pop   = ev_valid && ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            skip_q  <= 3'd0;
            lsh_q   <= 1'b0;
            rsh_q   <= 1'b0;
            caps_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            lsh_q   <= lsh_d;
            rsh_q   <= rsh_d;
            caps_q  <= caps_d;
            if (push && full && !pop) ovf_q <= 1'b1;
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {new_ext, new_brk, new_code, new_ascii};
    end

    assign ev_valid = (cnt_q != '0);
    assign ev_ext   = ev_valid ? mem_q[rd_q][17]    : 1'b0;
    assign ev_break = ev_valid ? mem_q[rd_q][16]    : 1'b0;
    assign ev_code  = ev_valid ? mem_q[rd_q][15:8]  : 8'h00;
    assign ev_ascii = ev_valid ? mem_q[rd_q][7:0]   : 8'h00;
    assign shift_o  = lsh_q | rsh_q;
    assign caps_o   = caps_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;
`ifdef PS2_DECODER_ASCII_EN
    localparam bit ASC = 1'b1;
`else
    localparam bit ASC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, shift_o, caps_o, overflow;
    logic [7:0] ev_code, ev_ascii;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_break(ev_break), .ev_ascii(ev_ascii),
        .shift_o(shift_o), .caps_o(caps_o), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] ascii;
    } ev_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending-prefix flags, key state and an event queue.
    ev_t mq[$];
    bit  m_e0, m_f0, m_lsh, m_rsh, m_caps, m_ovf;
    int  m_pause;

    logic [7:0] lcodes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dcodes [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    string      letters = "abcdefghijklmnopqrstuvwxyz";
    string      digits  = "1234567890";
    string      symbols = "!@#$%^&*()";

    function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh, input bit cp);
        if (!ASC) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (lcodes[i] == c) return (sh != cp) ? letters[i] - 8'd32 : letters[i];
        for (int i = 0; i < 10; i++)
            if (dcodes[i] == c) return sh ? symbols[i] : digits[i];
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    function automatic bit special(input logic [7:0] b);
        return b inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    task automatic model_byte(input logic [7:0] b, output bit got, output ev_t e);
        got = 0;
        e   = '0;
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin
                got = 1;
                e = '{ext: 1'b1, brk: 1'b0, code: 8'h77, ascii: 8'h00};
            end
        end else if (b == 8'hE1 && !m_e0 && !m_f0) m_pause = 7;
        else if (b == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1;
        else if (b == 8'hF0 && !m_f0) m_f0 = 1;
        else begin
            if (!special(b)) begin
                got = 1;
                e.ext  = m_e0;
                e.brk  = m_f0;
                e.code = b;
                e.ascii = (!m_e0 && !m_f0) ? ref_ascii(b, m_lsh | m_rsh, m_caps) : 8'h00;
            end
            m_e0 = 0;
            m_f0 = 0;
        end
        if (got && !e.ext) begin
            if (e.code == 8'h12) m_lsh = !e.brk;
            if (e.code == 8'h59) m_rsh = !e.brk;
            if (e.code == 8'h58 && !e.brk) m_caps = !m_caps;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_e0 = 0; m_f0 = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0; m_pause = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
        if (mq.size() != 0)
            check("head", 32'({ev_ext, ev_break, ev_code, ev_ascii}), 32'(mq[0]));
        check("shift", 32'(shift_o), 32'(m_lsh | m_rsh));
        check("caps", 32'(caps_o), 32'(m_caps));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: drive at the falling edge, check 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] b, input logic rdy);
        bit  got, pop;
        ev_t e;
        @(negedge clk);
        byte_valid = v;
        byte_data  = b;
        ev_ready   = rdy;
        pop = rdy && (mq.size() != 0);
        got = 0;
        if (v) model_byte(b, got, e);
        if (pop) void'(mq.pop_front());
        if (got) begin
            if (mq.size() >= DEPTH) m_ovf = 1;
            else mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check_outputs();
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        byte_valid = 1'b0;
        ev_ready = 1'b0;
        model_reset();
        #1;
        check("rst_status", 32'({ev_valid, shift_o, caps_o, overflow}), 32'd0);
        check("rst_head", 32'({ev_ext, ev_break, ev_code, ev_ascii}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    logic [7:0] pool [20] = '{8'hE0,8'hF0,8'hE1,8'hAA,8'h00,8'hFA,8'h12,8'h59,8'h58,8'h1C,
                              8'h32,8'h16,8'h29,8'h5A,8'h66,8'h75,8'h77,8'h14,8'h45,8'hF0};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_status", 32'({ev_valid, shift_o, caps_o, overflow}), 32'd0);
        check("por_head", 32'({ev_ext, ev_break, ev_code, ev_ascii}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single letter make
        step(1'b1, 8'h1C, 1'b0);
        check("req33_head", 32'({ev_ext, ev_break, ev_code, ev_ascii}),
              32'({1'b0, 1'b0, 8'h1C, ASC ? 8'h61 : 8'h00}));
        drain(2);

        // Shifted letter, then shift release
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h12, 1'b0);
        check("req34_shift_after", 32'(shift_o), 32'd0);
        step(1'b1, 8'h1C, 1'b0);
        drain(5);

        // Extended break and discarded replies
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        check("req35_head", 32'({ev_ext, ev_break, ev_code, ev_ascii}),
              32'({1'b1, 1'b1, 8'h75, 8'h00}));
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hFA, 1'b0);
        drain(3);

        // Overflow with no consumer
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h23, 1'b0);
        step(1'b1, 8'h24, 1'b0);
        step(1'b1, 8'h2B, 1'b0);
        check("req36_ovf", 32'(overflow), 32'd1);
        check("req36_head", 32'(ev_code), 32'h1C);
        // Full FIFO with simultaneous push and pop
        step(1'b1, 8'h29, 1'b1);
        drain(6);
        check("req36_empty", 32'({ev_valid, overflow}), 32'b01);

        // Reset mid-prefix
        do_reset();
        step(1'b1, 8'hE0, 1'b0);
        do_reset();
        step(1'b1, 8'h1C, 1'b0);
        check("req37_head", 32'({ev_ext, ev_break, ev_code}), 32'({1'b0, 1'b0, 8'h1C}));
        drain(2);

        // Pause sequence
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'h14, 1'b0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h14, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        check("req38_none_yet", 32'(ev_valid), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        check("req38_head", 32'({ev_ext, ev_break, ev_code, ev_ascii}),
              32'({1'b1, 1'b0, 8'h77, 8'h00}));
        step(1'b1, 8'h1C, 1'b1);
        drain(2);

        // Caps lock toggles and push/pop on an empty FIFO
        step(1'b1, 8'h58, 1'b1);
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h58, 1'b1);
        step(1'b1, 8'h1C, 1'b1);
        step(1'b1, 8'h59, 1'b1);
        step(1'b1, 8'h16, 1'b1);
        drain(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)],
                 ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end
        drain(DEPTH + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 byte_data  input  8  received PS/2 byte from the PS/2 receiver.
REQ-005 byte_valid  input  1  one-cycle strobe qualifying byte_data; no backpressure.
REQ-006 ev_valid  output  1  FIFO head holds an event.
REQ-007 ev_ready  input  1  consumer pops the head when ev_valid & ev_ready.
REQ-008 ev_code  output  8  head scancode (prefix bytes removed).
REQ-009 ev_ext  output  1  head was E0-prefixed.
REQ-010 ev_break  output  1  head is a key release (F0-prefixed).
REQ-011 ev_ascii  output  8  head ASCII value, 0x00 if none.
REQ-012 shift_o  output  1  either shift key currently held.
REQ-013 caps_o  output  1  caps-lock toggle state.
REQ-014 overflow  output  1  sticky: an event was dropped on a full FIFO.

Function
REQ-015 Prefix FSM states: IDLE, E0, F0, E0F0, PAUSE; it advances only on byte_valid.
REQ-016 IDLE: E0->E0; F0->F0; E1->PAUSE with skip count 7; AA/FA/FE/EE/00/FF are discarded; any other byte pushes a make event (ext=0) and stays in IDLE.
REQ-017 E0: F0->E0F0; E0/E1 and the discard set return to IDLE with no event; other bytes push a make event (ext=1) and go to IDLE.
REQ-018 F0: a non-prefix byte pushes a break event (ext=0) and goes to IDLE; a prefix or discard byte goes to IDLE with no event.
REQ-019 E0F0: a non-prefix byte pushes a break event (ext=1) and goes to IDLE; a prefix or discard byte goes to IDLE with no event.
REQ-020 PAUSE: discards bytes and decrements the count; on the 7th byte it pushes one make event code=0x77, ext=1, ascii=0, then goes to IDLE.
REQ-021 A push occurs in the same cycle as the final byte_valid; the event is visible on ev_valid on the next cycle (latency 1).
REQ-022 Shift tracking: a non-ext make of 0x12 or 0x59 sets that key's held bit; the matching break clears it; shift_o is the OR of both bits.
REQ-023 Caps tracking: each non-ext make of 0x58 toggles caps_o; typematic repeats also toggle.
REQ-024 Shift and caps are updated in the push cycle; the pushed ASCII uses the state before the update.
REQ-025 FIFO: first-word fall-through, FIFO_DEPTH entries, each {ext, break, code, ascii}.
REQ-026 A push to a full FIFO with no pop is dropped, and overflow is set and held until reset.
REQ-027 A push and a pop in the same cycle are both performed, including when the FIFO is full or empty-then-push.
REQ-028 Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 states wide.

Reset
REQ-029 Reset forces: FSM to IDLE, skip count 0, FIFO empty, ev_valid=0, ev_code/ev_ascii=0, ev_ext/ev_break=0, shift_o=0, caps_o=0, overflow=0.
REQ-030 Reset mid-sequence discards pending prefixes; the first byte after reset is decoded from IDLE.

Configuration
REQ-031 Macro PS2_DECODER_ASCII_EN: when defined, ev_ascii is produced from a set-2 table for non-ext make events.
- Letters 0x1C 'a'...: uppercase when shift_o XOR caps_o.
- Digits, space 0x29=0x20, enter 0x5A=0x0D, backspace 0x66=0x08: shifted symbols for digits when shift_o is set.
- All other codes: 0x00.
REQ-032 When PS2_DECODER_ASCII_EN is undefined, ev_ascii is constant 0x00 and no table logic is present; all other behaviour is unchanged.

Verification
REQ-033 Bytes 1C -> one event code=1C ext=0 break=0, ascii=0x61 (0x00 without the macro).
REQ-034 Bytes 12,1C,F0,12,1C -> events (12 make), (1C ascii=0x41), (12 break, shift_o=0 after), (1C ascii=0x61).
REQ-035 Bytes E0,F0,75 -> one event code=75 ext=1 break=1 ascii=0; bytes AA,FA -> no events.
REQ-036 ev_ready=0, six make bytes with FIFO_DEPTH=4 -> 4 events retained in order, overflow=1; drain -> ev_valid=0, overflow stays 1.
REQ-037 Byte E0, then reset pulse, then byte 1C -> one event code=1C ext=0.
REQ-038 Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one event code=77 ext=1 break=0, then IDLE.
